hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 45 ++++
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Pipeline hazard bundle: decode/execute/memory/writeback register tags and
// control flags in one direction, forwarding selects and stall controls in the other.
interface hazard_controller_if;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic [4:0]  WriteRegE;
    logic [4:0]  WriteRegM;
    logic [4:0]  WriteRegW;
    logic        RegWriteE;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        MemToRegE;
    logic        MemToRegM;
    logic        BranchD;
    logic        MdOpD;
    logic        MdReadD;
    logic        MdStartE;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic        forwardAD;
    logic        forwardBD;
    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic        MdBusy;
    logic [15:0] StallCount;

    modport master (
        output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
               BranchD, MdOpD, MdReadD, MdStartE,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
               StallF, StallD, FlushE, MdBusy, StallCount
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
               BranchD, MdOpD, MdReadD, MdStartE,
        output forwardAE, forwardBE, forwardAD, forwardBD,
               StallF, StallD, FlushE, MdBusy, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard unit: EX/decode forwarding, load-use, branch and
// mul/div stalls, an MDU busy tracker and a saturating stall-cycle counter.
module hazard_controller #(
    parameter int unsigned MDU_LAT = 32
) (
    input  logic              CLK,
    input  logic              RST,
    hazard_controller_if.slave hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mduState_t;

    localparam logic [7:0] CNT_LOAD = 8'(MDU_LAT - 1);

    mduState_t   stateReg, stateNext;
    logic [7:0]  cntReg, cntNext;
    logic [15:0] stallCountReg;

    logic [4:0]  srcE [2];
    logic [4:0]  srcD [2];
    logic [1:0]  fwdE [2];
    logic        fwdD [2];
    logic        lwStall, brStall, mdStall, stallAny;

    assign srcE[0] = hz.rsE;
    assign srcE[1] = hz.rtE;
    assign srcD[0] = hz.rsD;
    assign srcD[1] = hz.rtD;

    // One forwarding path per operand; MEM wins over WB because it is younger.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gFwd
            always_comb begin
                fwdE[gi] = 2'b00;
                if (!RST && srcE[gi] != 5'd0) begin
                    if (hz.RegWriteM && hz.WriteRegM == srcE[gi])
                        fwdE[gi] = 2'b10;
                    else if (hz.RegWriteW && hz.WriteRegW == srcE[gi])
                        fwdE[gi] = 2'b01;
                end
            end
            assign fwdD[gi] = !RST && srcD[gi] != 5'd0 && hz.RegWriteM
                              && hz.WriteRegM == srcD[gi];
        end
    endgenerate

    assign hz.forwardAE = fwdE[0];
    assign hz.forwardBE = fwdE[1];
    assign hz.forwardAD = fwdD[0];
    assign hz.forwardBD = fwdD[1];

    always_comb begin
        lwStall = hz.MemToRegE && hz.WriteRegE != 5'd0
                  && (hz.WriteRegE == hz.rsD || hz.WriteRegE == hz.rtD);
        brStall = hz.BranchD
                  && ((hz.RegWriteE && hz.WriteRegE != 5'd0
                       && (hz.WriteRegE == hz.rsD || hz.WriteRegE == hz.rtD))
                   || (hz.MemToRegM && hz.WriteRegM != 5'd0
                       && (hz.WriteRegM == hz.rsD || hz.WriteRegM == hz.rtD)));
        mdStall = (hz.MdOpD || hz.MdReadD) && (stateReg == BUSY);
        stallAny = !RST && (lwStall || brStall || mdStall);
    end

    assign hz.StallF     = stallAny;
    assign hz.StallD     = stallAny;
    // The ID/EX register is held as a bubble for the whole reset period.
    assign hz.FlushE     = RST || stallAny;
    assign hz.MdBusy     = !RST && (stateReg == BUSY);
    assign hz.StallCount = stallCountReg;

    // MDU occupancy: busy for cnt = MDU_LAT-1 down to 0, reloadable on the final cycle.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            IDLE: begin
                if (hz.MdStartE) begin
                    stateNext = BUSY;
                    cntNext   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cntReg != 8'd0) begin
                    cntNext = cntReg - 8'd1;
                end else if (hz.MdStartE) begin
                    cntNext = CNT_LOAD;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateReg <= IDLE;
            cntReg   <= 8'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stallCountReg <= 16'd0;
        end else if (stallAny && stallCountReg != 16'hFFFF) begin
            stallCountReg <= stallCountReg + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// traffic compared each cycle against a remaining-cycles reference model.
module tb_hazard_controller;

    localparam int LAT = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cycNum = 0;

    // Reference state: busy cycles still to come (including this one) and stall total.
    int   modelRemain = 0;
    int   modelCount = 0;

    hazard_controller_if hif ();

    hazard_controller #(.MDU_LAT(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hif)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycNum);
        end
    endtask

    function automatic int expFwdE(input logic [4:0] src);
        if (RST || src == 0) return 0;
        if (hif.RegWriteM && hif.WriteRegM == src) return 2;
        if (hif.RegWriteW && hif.WriteRegW == src) return 1;
        return 0;
    endfunction

    function automatic int expFwdD(input logic [4:0] src);
        return (!RST && src != 0 && hif.RegWriteM && hif.WriteRegM == src) ? 1 : 0;
    endfunction

    function automatic bit usesReg(input logic [4:0] r);
        return r != 0 && (r == hif.rsD || r == hif.rtD);
    endfunction

    function automatic int expStall();
        bit lw, br, md;
        lw = hif.MemToRegE && usesReg(hif.WriteRegE);
        br = hif.BranchD && ((hif.RegWriteE && usesReg(hif.WriteRegE))
                          || (hif.MemToRegM && usesReg(hif.WriteRegM)));
        md = (hif.MdOpD || hif.MdReadD) && modelRemain > 0;
        return (!RST && (lw || br || md)) ? 1 : 0;
    endfunction

    task automatic clearInputs();
        hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
        hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
        hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemToRegE = 0; hif.MemToRegM = 0; hif.BranchD = 0;
        hif.MdOpD = 0; hif.MdReadD = 0; hif.MdStartE = 0;
    endtask

    // Called shortly after a negedge with inputs already driven: compare, then advance.
    task automatic cycle();
        int st;
        #1;
        if (RST) begin
            modelRemain = 0;
            modelCount  = 0;
        end
        st = expStall();
        checkVal("forwardAE", int'(hif.forwardAE), expFwdE(hif.rsE));
        checkVal("forwardBE", int'(hif.forwardBE), expFwdE(hif.rtE));
        checkVal("forwardAD", int'(hif.forwardAD), expFwdD(hif.rsD));
        checkVal("forwardBD", int'(hif.forwardBD), expFwdD(hif.rtD));
        checkVal("StallF", int'(hif.StallF), st);
        checkVal("StallD", int'(hif.StallD), st);
        checkVal("FlushE", int'(hif.FlushE), (RST || st != 0) ? 1 : 0);
        checkVal("MdBusy", int'(hif.MdBusy), (!RST && modelRemain > 0) ? 1 : 0);
        checkVal("StallCount", int'(hif.StallCount), modelCount);
        $display("cyc %0d rst=%0b stall=%0d busy=%0b fwdAE=%0d fwdBE=%0d cnt=%0d",
                 cycNum, RST, st, hif.MdBusy, hif.forwardAE, hif.forwardBE, hif.StallCount);
        @(posedge CLK);
        if (!RST) begin
            if (st != 0 && modelCount < 65535) modelCount++;
            if (hif.MdStartE && modelRemain <= 1) modelRemain = LAT;
            else if (modelRemain > 0) modelRemain--;
        end
        cycNum++;
        @(negedge CLK);
    endtask

    initial begin
        int c0;
        clearInputs();
        RST = 1'b1;
        @(negedge CLK);
        #1;
        checkVal("rst_FlushE", int'(hif.FlushE), 1);
        checkVal("rst_StallD", int'(hif.StallD), 0);
        checkVal("rst_MdBusy", int'(hif.MdBusy), 0);
        checkVal("rst_StallCount", int'(hif.StallCount), 0);
        cycle();
        RST = 1'b0;
        cycle();

        // Forwarding priority and the zero register
        hif.rsE = 5; hif.RegWriteM = 1; hif.WriteRegM = 5; hif.RegWriteW = 1; hif.WriteRegW = 5;
        #1 checkVal("fwd_mem", int'(hif.forwardAE), 2);
        cycle();
        hif.WriteRegM = 6;
        #1 checkVal("fwd_wb", int'(hif.forwardAE), 1);
        cycle();
        hif.rsE = 0;
        #1 checkVal("fwd_r0", int'(hif.forwardAE), 0);
        cycle();
        clearInputs();

        // Load-use
        c0 = int'(hif.StallCount);
        hif.MemToRegE = 1; hif.WriteRegE = 8; hif.rtD = 8;
        #1 checkVal("lw_stall", int'(hif.StallD), 1);
        cycle();
        clearInputs();
        #1 checkVal("lw_count", int'(hif.StallCount), c0 + 1);
        cycle();

        // Branch depending on EX result, then forwarded from MEM
        hif.BranchD = 1; hif.rsD = 3; hif.RegWriteE = 1; hif.WriteRegE = 3;
        #1 checkVal("br_stall", int'(hif.StallD), 1);
        cycle();
        hif.RegWriteE = 0; hif.WriteRegE = 0; hif.WriteRegM = 3; hif.RegWriteM = 1;
        #1 checkVal("br_nostall", int'(hif.StallD), 0);
        checkVal("br_fwdAD", int'(hif.forwardAD), 1);
        cycle();
        clearInputs();

        // MDU busy window with a HI/LO read waiting on it
        hif.MdStartE = 1;
        cycle();
        hif.MdStartE = 0; hif.MdReadD = 1;
        for (int i = 0; i < LAT; i++) begin
            #1 checkVal("md_busy", int'(hif.MdBusy), 1);
            checkVal("md_stall", int'(hif.StallD), 1);
            cycle();
        end
        #1 checkVal("md_idle", int'(hif.MdBusy), 0);
        checkVal("md_release", int'(hif.StallD), 0);
        cycle();
        clearInputs();

        // Back-to-back reload on the final busy cycle, then reset mid-operation
        hif.MdStartE = 1;
        cycle();
        hif.MdStartE = 0;
        for (int i = 0; i < LAT - 1; i++) cycle();
        hif.MdStartE = 1;
        cycle();
        hif.MdStartE = 0;
        for (int i = 0; i < LAT; i++) begin
            #1 checkVal("b2b_busy", int'(hif.MdBusy), 1);
            cycle();
        end
        hif.MdStartE = 1;
        cycle();
        hif.MdStartE = 0; hif.MemToRegE = 1; hif.WriteRegE = 2; hif.rsD = 2;
        cycle();
        RST = 1'b1;
        #1 checkVal("rst_abort_busy", int'(hif.MdBusy), 0);
        checkVal("rst_abort_cnt", int'(hif.StallCount), 0);
        checkVal("rst_abort_flush", int'(hif.FlushE), 1);
        cycle();
        RST = 1'b0;
        clearInputs();
        hif.MdStartE = 1;
        cycle();
        hif.MdStartE = 0;
        #1 checkVal("post_rst_start", int'(hif.MdBusy), 1);
        cycle();

        // Random traffic on a small register set so matches are frequent
        for (int n = 0; n < 1500; n++) begin
            RST = ($urandom_range(0, 63) == 0);
            hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
            hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
            hif.WriteRegE = 5'($urandom_range(0, 3));
            hif.WriteRegM = 5'($urandom_range(0, 3));
            hif.WriteRegW = 5'($urandom_range(0, 3));
            hif.RegWriteE = 1'($urandom); hif.RegWriteM = 1'($urandom);
            hif.RegWriteW = 1'($urandom);
            hif.MemToRegE = ($urandom_range(0, 3) == 0);
            hif.MemToRegM = ($urandom_range(0, 3) == 0);
            hif.BranchD   = ($urandom_range(0, 3) == 0);
            hif.MdOpD     = ($urandom_range(0, 5) == 0);
            hif.MdReadD   = ($urandom_range(0, 5) == 0);
            hif.MdStartE  = ($urandom_range(0, 7) == 0);
            cycle();
        end
        RST = 1'b0;
        clearInputs();
        cycle();

        // Saturation: hold a load-use stall for 70000 edges
        hif.MemToRegE = 1; hif.WriteRegE = 8; hif.rtD = 8;
        #1;
        repeat (70000) @(posedge CLK);
        modelCount  = (modelCount + 70000 > 65535) ? 65535 : modelCount + 70000;
        modelRemain = 0;
        cycNum += 70000;
        @(negedge CLK);
        $display("cyc %0d saturation run of 70000 stall cycles done cnt=%0d", cycNum, hif.StallCount);
        #1 checkVal("sat_value", int'(hif.StallCount), 16'hFFFF);
        cycle();
        cycle();
        #1 checkVal("sat_hold", int'(hif.StallCount), 16'hFFFF);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
